// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive timing/control: sync, start qualify, mid-bit strobes, stop check, holding register
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic [DATA_BITS:0]   packet_data,
    output logic                 serial_sync,
    output logic                 shift_strobe,
    output logic                 receiving,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    input  logic                 data_read,
    output logic                 overrun_error,
    output logic                 framing_error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 2);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_C  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [BW-1:0] LAST_B  = BW'(DATA_BITS);
    localparam logic [BW-1:0] ONE_B   = BW'(1);

    typedef enum logic [1:0] {IDLE, START, RECEIVE, CHECK} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 ready_q, ready_d;
    logic                 ovr_q, ovr_d;
    logic                 frm_q, frm_d;
    logic                 start_edge;

    // Sync flops reset high so releasing reset on an idle line cannot look like a start edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            rx_data_q <= '0;
            ready_q   <= 1'b0;
            ovr_q     <= 1'b0;
            frm_q     <= 1'b0;
        end else begin
            sync1_q   <= serial_in;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            rx_data_q <= rx_data_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
            frm_q     <= frm_d;
        end
    end

    assign start_edge = prev_q & ~sync2_q;

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        bit_d        = bit_q;
        rx_data_d    = rx_data_q;
        ready_d      = ready_q;
        ovr_d        = ovr_q;
        frm_d        = frm_q;
        shift_strobe = 1'b0;
        if (data_read) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end
        case (state_q)
            IDLE: begin
                cyc_d = '0;
                bit_d = '0;
                if (start_edge) state_d = START;
            end
            START: begin
                cyc_d = cyc_q + ONE_C;
                if (cyc_q == HALF_M1) begin
                    cyc_d = '0;
                    if (sync2_q) begin
                        state_d = IDLE;
                    end else begin
                        frm_d   = 1'b0;
                        state_d = RECEIVE;
                    end
                end
            end
            RECEIVE: begin
                cyc_d = cyc_q + ONE_C;
                if (cyc_q == LAST_C) begin
                    cyc_d        = '0;
                    shift_strobe = 1'b1;
                    bit_d        = bit_q + ONE_B;
                    if (bit_q == LAST_B) state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
                // A load beats a coincident read: ready stays set, overrun only if unread.
                if (packet_data[DATA_BITS]) begin
                    rx_data_d = packet_data[DATA_BITS-1:0];
                    ready_d   = 1'b1;
                    if (ready_q && !data_read) ovr_d = 1'b1;
                end else begin
                    frm_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign serial_sync   = sync2_q;
    assign receiving     = (state_q != IDLE);
    assign rx_data       = rx_data_q;
    assign data_ready    = ready_q;
    assign overrun_error = ovr_q;
    assign framing_error = frm_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl with a 9-bit LSB-first shift register model
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       serial_in;
    logic [8:0] sr;
    logic       serial_sync, shift_strobe, receiving;
    logic [7:0] rx_data;
    logic       data_ready, data_read, overrun_error, framing_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         nstrb;
        int         first_off;
        int         len;
        logic [7:0] rx;
        logic       rdy;
        logic       ovr;
        logic       frm;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    uart_rx_ctrl #(.CLKS_PER_BIT(10), .DATA_BITS(8)) dut (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .packet_data(sr),
        .serial_sync(serial_sync), .shift_strobe(shift_strobe), .receiving(receiving),
        .rx_data(rx_data), .data_ready(data_ready), .data_read(data_read),
        .overrun_error(overrun_error), .framing_error(framing_error)
    );

    always #5 clk = ~clk;

    // Downstream shift register: new bit enters at the top, first bit ends in [0].
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) sr <= '1;
        else if (shift_strobe) sr <= {serial_sync, sr[8:1]};
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    int cyc = 0, start_cyc = 0, nstrb = 0, first_off = -1, last_off = 0, space_bad = 0, off;
    bit in_frame = 1'b0;

    always @(negedge clk) begin
        if (!n_rst) begin
            in_frame = 1'b0;
        end else begin
            if (in_frame && !receiving) begin
                in_frame = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got a frame end expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_count", nstrb, e.nstrb);
                    check("first_strobe_offset", first_off, e.first_off);
                    check("strobe_spacing_errors", space_bad, 0);
                    check("receiving_length", cyc - start_cyc, e.len);
                    check("rx_data", rx_data, e.rx);
                    check("data_ready", data_ready, e.rdy);
                    check("overrun_error", overrun_error, e.ovr);
                    check("framing_error", framing_error, e.frm);
                end
            end else if (!in_frame && receiving) begin
                in_frame  = 1'b1;
                start_cyc = cyc;
                nstrb     = 0;
                first_off = -1;
                space_bad = 0;
            end
            if (shift_strobe) begin
                if (!in_frame) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_strobe: got strobe outside frame expected none");
                end else begin
                    off = cyc - start_cyc;
                    if (nstrb == 0) first_off = off;
                    else if (off - last_off != 10) space_bad++;
                    last_off = off;
                    nstrb++;
                end
            end
        end
        cyc++;
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(logic [7:0] d, logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_in = bits[i];
            step(10);
        end
        serial_in = 1'b1;
    endtask

    task automatic push_exp(logic [7:0] rx, logic rdy, logic ovr, logic frm);
        exp_q.push_back('{9, 14, 96, rx, rdy, ovr, frm});
    endtask

    task automatic read_pulse();
        data_read = 1'b1;
        step(1);
        data_read = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_serial_sync"}, serial_sync, 1);
        check({tag, "_shift_strobe"}, shift_strobe, 0);
        check({tag, "_receiving"}, receiving, 0);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_data_ready"}, data_ready, 0);
        check({tag, "_overrun"}, overrun_error, 0);
        check({tag, "_framing"}, framing_error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0;
        serial_in = 1'b1;
        data_read = 1'b0;
        step(3);
        check_reset_outputs("por");
        n_rst = 1'b1;
        step(5);

        push_exp(8'hA5, 1, 0, 0);
        send_frame(8'hA5, 1'b1);
        step(5);

        exp_q.push_back('{0, -1, 5, 8'hA5, 1'b1, 1'b0, 1'b0});
        serial_in = 1'b0;
        step(3);
        serial_in = 1'b1;
        step(15);

        read_pulse();
        check("read_clears_ready", data_ready, 0);
        read_pulse();
        check("read_when_empty_ready", data_ready, 0);
        check("read_when_empty_rx", rx_data, 8'hA5);

        push_exp(8'hA5, 0, 0, 1);
        send_frame(8'h3C, 1'b0);
        step(5);
        push_exp(8'h11, 1, 0, 0);
        send_frame(8'h11, 1'b1);
        step(5);

        read_pulse();
        check("read_before_overrun", data_ready, 0);
        push_exp(8'h01, 1, 0, 0);
        send_frame(8'h01, 1'b1);
        push_exp(8'h02, 1, 1, 0);
        send_frame(8'h02, 1'b1);
        step(5);
        check("overrun_held", overrun_error, 1);
        read_pulse();
        check("read_clears_ready_ovr", data_ready, 0);
        check("read_clears_overrun", overrun_error, 0);

        push_exp(8'h66, 1, 0, 0);
        send_frame(8'h66, 1'b1);
        push_exp(8'h55, 1, 0, 0);
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (98) @(posedge clk);
                #1 data_read = 1'b1;
                @(posedge clk);
                #1 data_read = 1'b0;
            end
        join
        step(5);

        serial_in = 1'b0;
        step(30);
        check("midframe_receiving", receiving, 1);
        n_rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        serial_in = 1'b1;
        step(3);
        n_rst = 1'b1;
        step(40);
        check("post_reset_receiving", receiving, 0);
        check("post_reset_ready", data_ready, 0);

        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step(1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side timing and control stage for the UART receiver.
- Synchronizes the raw line, detects and qualifies start bits, and times mid-bit shift strobes into the downstream flexible serial-to-parallel shift register.
- Checks the stop bit in the register's parallel output and buffers good bytes into a host-readable holding register with ready, overrun and framing flags.
- Sits between the RX pin and the host read interface, wrapping the shift register, which is configured NUM_BITS = DATA_BITS+1, LSB-first.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit; even, >= 4
DATA_BITS, 8, data bits per frame; the shift register holds DATA_BITS+1 (data + stop)

Ports:
clk  input  1  system clock, all state on rising edge
n_rst  input  1  asynchronous active-low reset
serial_in  input  1  raw asynchronous RX line, idle high
packet_data  input  DATA_BITS+1  shift register parallel_out; [DATA_BITS] = stop bit, [DATA_BITS-1:0] = data, LSB first
serial_sync  output  1  2-flop-synchronized line; drives the shift register serial_in
shift_strobe  output  1  one-cycle pulse; drives the shift register shift_enable
receiving  output  1  high while the FSM is not IDLE
rx_data  output  DATA_BITS  last good received byte
data_ready  output  1  rx_data holds an unread byte
data_read  input  1  host pulse acknowledging rx_data
overrun_error  output  1  a good byte arrived while data_ready was still set
framing_error  output  1  last frame had stop bit = 0

Behaviour:
- Reset (async, any state, mid-frame included):
  - sync flops and prior-sample flop = 1, so no false edge appears after release.
  - serial_sync = 1; shift_strobe, receiving, data_ready, overrun_error, framing_error = 0; rx_data = 0.
  - FSM = IDLE, timer = 0.
- Synchronizer: serial_sync lags serial_in by 2 clocks. All decisions use serial_sync only.
- start_edge: registered previous serial_sync = 1 and current = 0. Acted on only in IDLE. Call the cycle it is high T.
- FSM states:
  - IDLE -> START at T+1; timer cleared.
  - START: at T+CLKS_PER_BIT/2, sample serial_sync.
    - 1 (glitch): -> IDLE; no strobe issued; flags untouched.
    - 0 (valid start): framing_error cleared; -> RECEIVE.
  - RECEIVE: shift_strobe high for exactly one cycle at T+CLKS_PER_BIT/2+k*CLKS_PER_BIT, for k = 1..DATA_BITS+1. That is DATA_BITS+1 strobes; the last one captures the stop bit. Cycle after the last strobe -> CHECK.
  - CHECK (one cycle; packet_data now holds the full frame):
    - packet_data[DATA_BITS] = 1: rx_data <= packet_data[DATA_BITS-1:0], data_ready <= 1.
    - packet_data[DATA_BITS] = 1 and data_ready already 1 with data_read not asserted: also overrun_error <= 1; new byte overwrites.
    - packet_data[DATA_BITS] = 0: framing_error <= 1; rx_data and data_ready unchanged.
    - -> IDLE.
- receiving = 1 in START, RECEIVE and CHECK.
- Edges on serial_sync outside IDLE are ignored, i.e. no re-sync mid-frame.
- data_read: clears data_ready and overrun_error on the next edge.
- Load in CHECK coincident with data_read: load wins. data_ready stays 1; overrun_error is not set but is cleared.
- data_read while data_ready = 0: no effect.
- Back-to-back frames: a new start edge immediately after the stop bit is accepted once the FSM is in IDLE. Minimum frame-to-frame spacing is DATA_BITS+1.5 bit times plus 2 cycles from the start edge; the stop bit covers this.
- Timer width: ceil(log2(CLKS_PER_BIT*(DATA_BITS+2))) bits, or a bit counter plus a cycle counter; no wrap within a frame.

Test Plan:
(All scenarios use CLKS_PER_BIT=10, DATA_BITS=8, with the shift register instantiated NUM_BITS=9, SHIFT_MSB=0.)
1. Reset mid-frame: assert n_rst low during RECEIVE -> all outputs at reset values immediately; no strobe after release; line idle high gives no start_edge.
2. Single frame 0xA5, stop=1, 10 cycles/bit -> 9 strobes at T+15, T+25, ..., T+95; rx_data = 0xA5; data_ready = 1 at T+97; framing_error = 0.
3. Glitch: line low for 3 cycles then high -> return to IDLE at T+5; zero strobes; data_ready unchanged.
4. Frame 0x3C with stop=0 -> framing_error = 1; rx_data and data_ready keep prior values. Next good frame 0x11 -> framing_error cleared at its START check; rx_data = 0x11.
5. Overrun: two good frames 0x01 then 0x02, no data_read -> rx_data = 0x02, data_ready = 1, overrun_error = 1. Pulse data_read -> both flags 0 next cycle.
6. data_read pulsed in the CHECK cycle of frame 0x55 while data_ready = 1 -> rx_data = 0x55, data_ready stays 1, overrun_error = 0.
